// File: rtl/traffic_phase_controller.sv
// traffic_phase_controller
//   N-approach intersection phase sequencer: ALL_RED -> GREEN -> AMBER -> ALL_RED.
//   Durations are counted in `tick` strobes. Emergency requests win the grant,
//   can truncate a non-emergency green and hold their own green. Load requests
//   are served round-robin after the last served approach.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   tick                one-cycle timebase strobe
//   green_len/amber_len phase lengths in ticks (0 behaves as 1), sampled on phase entry
//   load_req/emer_req   per-approach level requests
//   red/amber/green     registered lamp outputs, exactly one set per approach
//   active_dir          approach served (GREEN/AMBER) or last served (ALL_RED)
//   emer_active         current GREEN/AMBER was granted by an emergency
//   phase_done          one-cycle pulse when ALL_RED is entered from AMBER
module traffic_phase_controller #(
  parameter int  NUM_DIRS     = 4,
  parameter int  CNT_W        = 6,
  parameter int  ALLRED_TICKS = 1,
  localparam int DIR_W        = ($clog2(NUM_DIRS) < 1) ? 1 : $clog2(NUM_DIRS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick,
  input  logic [CNT_W-1:0]    green_len,
  input  logic [CNT_W-1:0]    amber_len,
  input  logic [NUM_DIRS-1:0] load_req,
  input  logic [NUM_DIRS-1:0] emer_req,
  output logic [NUM_DIRS-1:0] red,
  output logic [NUM_DIRS-1:0] amber,
  output logic [NUM_DIRS-1:0] green,
  output logic [DIR_W-1:0]    active_dir,
  output logic                emer_active,
  output logic                phase_done
);

  typedef enum logic [1:0] {S_ALL_RED, S_GREEN, S_AMBER} state_e;

  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ALLRED = CNT_W'(ALLRED_TICKS);
  localparam logic [DIR_W-1:0] DIR_LAST   = DIR_W'(NUM_DIRS - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DIR_W-1:0]    last_dir_q, last_dir_d;
  logic [DIR_W-1:0]    active_dir_q, active_dir_d;
  logic                emer_phase_q, emer_phase_d;
  logic [NUM_DIRS-1:0] red_q, red_d, amber_q, amber_d, green_q, green_d;
  logic                emer_active_q, emer_active_d;
  logic                phase_done_q, phase_done_d;

  logic [DIR_W-1:0]    next_dir, grant;
  logic                grant_emer, found;
  logic [NUM_DIRS-1:0] act_mask, new_mask;
  logic [CNT_W-1:0]    green_eff, amber_eff;
  logic                preempt, hold;

  function automatic logic sel(input logic [NUM_DIRS-1:0] v, input int unsigned i);
    logic [NUM_DIRS-1:0] s;
    s = v >> i;
    return s[0];
  endfunction

  function automatic logic [NUM_DIRS-1:0] onehot(input logic [DIR_W-1:0] d);
    logic [NUM_DIRS-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < NUM_DIRS; i++)
      if (d == DIR_W'(i)) m = NUM_DIRS'(1) << i;
    return m;
  endfunction

  // Grant for the ALL_RED exit: emergency lowest index, else load round-robin
  // starting after last_dir, else plain rotation.
  always_comb begin
    int unsigned idx;
    idx        = 0;
    next_dir   = (last_dir_q == DIR_LAST) ? '0 : last_dir_q + 1'b1;
    grant      = next_dir;
    grant_emer = 1'b0;
    found      = 1'b0;
    if (|emer_req) begin
      grant_emer = 1'b1;
      for (int unsigned i = 0; i < NUM_DIRS; i++) begin
        if (!found && sel(emer_req, i)) begin
          grant = DIR_W'(i);
          found = 1'b1;
        end
      end
    end else if (|load_req) begin
      for (int unsigned k = 0; k < NUM_DIRS; k++) begin
        idx = 32'(next_dir) + k;
        if (idx >= NUM_DIRS) idx = idx - NUM_DIRS;
        if (!found && sel(load_req, idx)) begin
          grant = DIR_W'(idx);
          found = 1'b1;
        end
      end
    end
  end

  assign green_eff = (green_len == '0) ? CNT_ONE : green_len;
  assign amber_eff = (amber_len == '0) ? CNT_ONE : amber_len;
  assign act_mask  = onehot(active_dir_q);
  assign preempt   = !emer_phase_q && |(emer_req & ~act_mask);
  assign hold      = |(emer_req & act_mask);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_dir_d   = last_dir_q;
    active_dir_d = active_dir_q;
    emer_phase_d = emer_phase_q;
    phase_done_d = 1'b0;
    if (tick) begin
      unique case (state_q)
        S_ALL_RED: begin
          if (cnt_q > CNT_ONE) cnt_d = cnt_q - 1'b1;
          else begin
            state_d      = S_GREEN;
            cnt_d        = green_eff;
            active_dir_d = grant;
            last_dir_d   = grant;
            emer_phase_d = grant_emer;
          end
        end
        S_GREEN: begin
          // Preemption ends the green regardless of cnt; an emergency on the
          // active approach only pins cnt at 1.
          if (preempt) begin
            state_d = S_AMBER;
            cnt_d   = amber_eff;
          end else if (cnt_q > CNT_ONE) cnt_d = cnt_q - 1'b1;
          else if (!hold) begin
            state_d = S_AMBER;
            cnt_d   = amber_eff;
          end
        end
        S_AMBER: begin
          if (cnt_q > CNT_ONE) cnt_d = cnt_q - 1'b1;
          else begin
            state_d      = S_ALL_RED;
            cnt_d        = CNT_ALLRED;
            phase_done_d = 1'b1;
          end
        end
        default: state_d = S_ALL_RED;
      endcase
    end
    // Outputs are decoded from next-state values so they register with the state.
    new_mask      = onehot(active_dir_d);
    green_d       = (state_d == S_GREEN) ? new_mask : '0;
    amber_d       = (state_d == S_AMBER) ? new_mask : '0;
    red_d         = ~(green_d | amber_d);
    emer_active_d = emer_phase_d && (state_d != S_ALL_RED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_ALL_RED;
      cnt_q         <= CNT_ALLRED;
      last_dir_q    <= DIR_LAST;
      active_dir_q  <= '0;
      emer_phase_q  <= 1'b0;
      red_q         <= '1;
      amber_q       <= '0;
      green_q       <= '0;
      emer_active_q <= 1'b0;
      phase_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      last_dir_q    <= last_dir_d;
      active_dir_q  <= active_dir_d;
      emer_phase_q  <= emer_phase_d;
      red_q         <= red_d;
      amber_q       <= amber_d;
      green_q       <= green_d;
      emer_active_q <= emer_active_d;
      phase_done_q  <= phase_done_d;
    end
  end

  assign red         = red_q;
  assign amber       = amber_q;
  assign green       = green_q;
  assign active_dir  = active_dir_q;
  assign emer_active = emer_active_q;
  assign phase_done  = phase_done_q;

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Bench for traffic_phase_controller: directed scenarios plus randomized traffic,
// every cycle compared against a behavioural phase model.
module tb_traffic_phase_controller;
  localparam int N  = 4;
  localparam int CW = 6;
  localparam int AR = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          tick = 1'b0;
  logic [CW-1:0] green_len = '0;
  logic [CW-1:0] amber_len = '0;
  logic [N-1:0]  load_req = '0;
  logic [N-1:0]  emer_req = '0;
  logic [N-1:0]  red, amber, green;
  logic [1:0]    active_dir;
  logic          emer_active, phase_done;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model: phase 0 = all red, 1 = green, 2 = amber.
  int m_phase, m_left, m_last, m_act;
  bit m_emer, m_done;

  always #5 clk = ~clk;

  traffic_phase_controller #(.NUM_DIRS(N), .CNT_W(CW), .ALLRED_TICKS(AR)) dut (
    .clk(clk), .rst(rst), .tick(tick), .green_len(green_len), .amber_len(amber_len),
    .load_req(load_req), .emer_req(emer_req), .red(red), .amber(amber), .green(green),
    .active_dir(active_dir), .emer_active(emer_active), .phase_done(phase_done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_phase = 0; m_left = AR; m_last = N - 1; m_act = 0; m_emer = 0; m_done = 0;
  endfunction

  function automatic void model_step();
    int w;
    int len;
    m_done = 0;
    if (!tick) return;
    if (m_phase == 0) begin
      if (m_left > 1) m_left--;
      else begin
        w = -1;
        if (emer_req != 0) begin
          for (int d = N - 1; d >= 0; d--) if (emer_req[d]) w = d;
          m_emer = 1;
        end else begin
          m_emer = 0;
          for (int k = N; k >= 1; k--) if (load_req[(m_last + k) % N]) w = (m_last + k) % N;
          if (w < 0) w = (m_last + 1) % N;
        end
        m_act = w; m_last = w;
        len = int'(green_len); m_left = (len == 0) ? 1 : len;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      len = int'(amber_len);
      if (!m_emer && (emer_req & ~(4'b0001 << m_act)) != 0) begin
        m_phase = 2; m_left = (len == 0) ? 1 : len;
      end else if (m_left > 1) m_left--;
      else if (!emer_req[m_act]) begin
        m_phase = 2; m_left = (len == 0) ? 1 : len;
      end
    end else begin
      if (m_left > 1) m_left--;
      else begin m_phase = 0; m_left = AR; m_done = 1; end
    end
  endfunction

  task automatic check_all(input string tag);
    logic [N-1:0] er, ea, eg;
    er = '0; ea = '0; eg = '0;
    for (int d = 0; d < N; d++) begin
      if (m_phase != 0 && d == m_act) begin
        if (m_phase == 1) eg[d] = 1'b1; else ea[d] = 1'b1;
      end else er[d] = 1'b1;
    end
    chk({tag, ".red"}, 32'(red), 32'(er));
    chk({tag, ".amber"}, 32'(amber), 32'(ea));
    chk({tag, ".green"}, 32'(green), 32'(eg));
    chk({tag, ".active_dir"}, 32'(active_dir), 32'(m_act));
    chk({tag, ".emer_active"}, 32'(emer_active), 32'(m_phase != 0 && m_emer));
    chk({tag, ".phase_done"}, 32'(phase_done), 32'(m_done));
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    if (rst) model_reset(); else model_step();
    #1 check_all(tag);
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1 model_reset();
    chk("async_rst.red", 32'(red), 32'hF);
    chk("async_rst.green", 32'(green), 32'h0);
    chk("async_rst.amber", 32'(amber), 32'h0);
    chk("async_rst.active_dir", 32'(active_dir), 32'h0);
    check_all("async_rst");
    cycle("in_rst");
    rst = 1'b0;
  endtask

  initial begin
    int em_hold;
    model_reset();
    // Reset asserted mid-GREEN with no clock edge
    cycle("rst0");
    rst = 1'b0;
    tick = 1'b1; green_len = 6'd5; amber_len = 6'd2;
    cycle("pre_green");
    cycle("in_green");
    chk("mid_green.green", 32'(green), 32'h1);
    do_reset();

    // Rotation with no requests: one approach every 6 ticks
    green_len = 6'd3; amber_len = 6'd2; tick = 1'b1;
    for (int c = 1; c <= 25; c++) begin
      cycle("rot");
      if (c % 6 == 1) chk("rot.grant", 32'(green), 32'(4'b0001 << ((c / 6) % 4)));
      if (c % 6 == 0) chk("rot.done", 32'(phase_done), 32'h1);
    end

    // Load round-robin with load_req=1001: grants 0,3,0,3
    do_reset();
    green_len = 6'd1; amber_len = 6'd1; load_req = 4'b1001;
    for (int c = 1; c <= 12; c++) begin
      cycle("rr");
      if (c % 3 == 1) chk("rr.grant", 32'(active_dir), ((c / 3) % 2 == 0) ? 32'd0 : 32'd3);
    end
    load_req = '0;

    // Preemption of approach 1's green by emer_req=0100
    do_reset();
    green_len = 6'd3; amber_len = 6'd2;
    for (int c = 1; c <= 7; c++) cycle("pre_a");
    chk("pre.green1", 32'(green), 32'h2);
    emer_req = 4'b0100;
    cycle("pre_b");
    chk("pre.amber1", 32'(amber), 32'h2);
    cycle("pre_c");
    cycle("pre_d");
    chk("pre.allred", 32'(red), 32'hF);
    chk("pre.done", 32'(phase_done), 32'h1);
    cycle("pre_e");
    chk("pre.green2", 32'(green), 32'h4);
    chk("pre.emer", 32'(emer_active), 32'h1);
    for (int c = 0; c < 5; c++) cycle("pre_hold");
    emer_req = '0;
    for (int c = 0; c < 6; c++) cycle("pre_tail");

    // Emergency tie-break (1010 -> 1) and 20-tick hold
    do_reset();
    emer_req = 4'b1010;
    cycle("eh_grant");
    chk("eh.grant", 32'(active_dir), 32'd1);
    emer_req = 4'b0010;
    for (int c = 0; c < 20; c++) begin
      cycle("eh_hold");
      chk("eh.held", 32'(green), 32'h2);
    end
    emer_req = '0;
    cycle("eh_exit");
    chk("eh.amber", 32'(amber), 32'h2);
    for (int c = 0; c < 4; c++) cycle("eh_tail");

    // Zero lengths, tick every 4 cycles: each state holds 4 cycles
    do_reset();
    green_len = '0; amber_len = '0;
    for (int c = 0; c < 24; c++) begin
      tick = (c % 4 == 3);
      cycle("zero");
      if (c % 4 == 3) begin
        case ((c / 4) % 3)
          0: chk("zero.green", 32'(green), 32'(4'b0001 << ((c / 12) % 4)));
          1: chk("zero.amber", 32'(amber), 32'(4'b0001 << ((c / 12) % 4)));
          default: chk("zero.allred", 32'(red), 32'hF);
        endcase
      end
    end

    // Randomized traffic
    em_hold = 0;
    for (int c = 0; c < 2000; c++) begin
      tick = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 19) == 0) green_len = CW'($urandom_range(0, 4));
      if ($urandom_range(0, 19) == 0) amber_len = CW'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) load_req = N'($urandom_range(0, 15));
      if (em_hold > 0) em_hold--;
      else if ($urandom_range(0, 29) == 0) begin
        emer_req = N'($urandom_range(1, 15)); em_hold = $urandom_range(2, 25);
      end else emer_req = '0;
      if (c == 1000) do_reset();
      else cycle("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
